// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants: standard geometries, sync placement and polarity,
// plus the geometry legality check used when loading new porch values.
package vga_timing_gen_pkg;

  typedef struct packed {
    int unsigned h_total;
    int unsigned h_active;
    int unsigned v_total;
    int unsigned v_active;
  } vga_geom_t;

  localparam vga_geom_t VGA_640X480  = '{h_total: 800,  h_active: 640,  v_total: 525, v_active: 480};
  localparam vga_geom_t VGA_800X600  = '{h_total: 1056, h_active: 800,  v_total: 628, v_active: 600};
  localparam vga_geom_t VGA_1024X768 = '{h_total: 1344, h_active: 1024, v_total: 806, v_active: 768};

  localparam int unsigned VGA_H_SYNC_OFFSET = 16;
  localparam int unsigned VGA_H_SYNC_LEN    = 96;
  localparam int unsigned VGA_V_SYNC_OFFSET = 10;
  localparam int unsigned VGA_V_SYNC_LEN    = 2;

  localparam logic VGA_SYNC_POL = 1'b0;

  // One axis is legal when active < total, sync fits after active, nothing is zero.
  function automatic logic geom_ok(int unsigned act, int unsigned tot,
                                   int unsigned off, int unsigned len);
    return (act != 0) && (tot != 0) && (act < tot) && (act + off + len <= tot);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Clock-rate shift register aligning {active, hsync, vsync} with the pixel data path.
module vga_sync_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  // Next state: new entry at stage 0, every other stage takes its predecessor.
  always_comb begin
    pipe_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Delay line resets to all-inactive entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '{default: '0};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider, H/V counters with frame-boundary shadow
// geometry, sync generation and blanked RGB output.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH    = 11,
  parameter int unsigned BACKPORCH_WIDTH  = 11,
  parameter int unsigned FRONTPORCH_WIDTH = 11,
  parameter int unsigned DATA_WIDTH       = 12,
  parameter int unsigned PIX_DIV          = 2,
  parameter int unsigned H_SYNC_OFFSET    = VGA_H_SYNC_OFFSET,
  parameter int unsigned H_SYNC_LEN       = VGA_H_SYNC_LEN,
  parameter int unsigned V_SYNC_OFFSET    = VGA_V_SYNC_OFFSET,
  parameter int unsigned V_SYNC_LEN       = VGA_V_SYNC_LEN,
  parameter logic        SYNC_POL         = VGA_SYNC_POL,
  parameter int unsigned PIPE_DELAY       = 1,
  parameter int unsigned H_TOTAL_RST      = VGA_640X480.h_total,
  parameter int unsigned H_ACTIVE_RST     = VGA_640X480.h_active,
  parameter int unsigned V_TOTAL_RST      = VGA_640X480.v_total,
  parameter int unsigned V_ACTIVE_RST     = VGA_640X480.v_active
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BACKPORCH_WIDTH-1:0]  H_BackPorch,
  input  logic [FRONTPORCH_WIDTH-1:0] H_FrontPorch,
  input  logic [BACKPORCH_WIDTH-1:0]  V_BackPorch,
  input  logic [FRONTPORCH_WIDTH-1:0] V_FrontPorch,
  input  logic [DATA_WIDTH-1:0]       Data_VGA,
  output logic [COUNTER_WIDTH-1:0]    Counter_X,
  output logic                        Counter_X_Valid,
  output logic [COUNTER_WIDTH-1:0]    Counter_Y,
  output logic                        Counter_Y_Valid,
  output logic                        HSYNC,
  output logic                        VSYNC,
  output logic [DATA_WIDTH-1:0]       RGB,
  output logic                        Frame_Start,
  output logic                        Cfg_Error
);

  localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0]            div_q, div_d;
  logic [COUNTER_WIDTH-1:0]    h_q, h_d, v_q, v_d;
  logic [BACKPORCH_WIDTH-1:0]  htot_q, htot_d, vtot_q, vtot_d;
  logic [FRONTPORCH_WIDTH-1:0] hact_q, hact_d, vact_q, vact_d;
  logic                        x_valid_q, x_valid_d, y_valid_q, y_valid_d;
  logic                        frame_start_q, frame_start_d, cfg_err_q, cfg_err_d;
  logic                        hsync_q, hsync_d, vsync_q, vsync_d;
  logic [DATA_WIDTH-1:0]       rgb_q, rgb_d;
  logic                        tick, h_wrap, v_wrap, boundary, cfg_ok;
  logic                        hsync_raw, vsync_raw;
  logic [2:0]                  sync_in, sync_out;

  // Divider, counters and shadow geometry; wrap uses >= so a counter can never run past total-1.
  always_comb begin
    tick     = (32'(div_q) >= PIX_DIV - 1);
    div_d    = tick ? '0 : div_q + 1'b1;
    h_wrap   = (32'(h_q) + 1 >= 32'(htot_q));
    v_wrap   = (32'(v_q) + 1 >= 32'(vtot_q));
    boundary = tick & h_wrap & v_wrap;
    cfg_ok   = geom_ok(32'(H_FrontPorch), 32'(H_BackPorch), H_SYNC_OFFSET, H_SYNC_LEN) &&
               geom_ok(32'(V_FrontPorch), 32'(V_BackPorch), V_SYNC_OFFSET, V_SYNC_LEN);
    h_d       = h_q;
    v_d       = v_q;
    htot_d    = htot_q;
    hact_d    = hact_q;
    vtot_d    = vtot_q;
    vact_d    = vact_q;
    cfg_err_d = cfg_err_q;
    if (tick) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    if (boundary) begin
      cfg_err_d = !cfg_ok;
      if (cfg_ok) begin
        htot_d = H_BackPorch;
        hact_d = H_FrontPorch;
        vtot_d = V_BackPorch;
        vact_d = V_FrontPorch;
      end
    end
    // Valid flags follow the next counter value against the geometry that will apply with it.
    x_valid_d     = (32'(h_d) < 32'(hact_d));
    y_valid_d     = (32'(v_d) < 32'(vact_d));
    frame_start_d = boundary;
  end

  // Raw sync windows and the blanked output stage fed by the delay line.
  always_comb begin
    hsync_raw = (32'(h_q) >= 32'(hact_q) + H_SYNC_OFFSET) &&
                (32'(h_q) <  32'(hact_q) + H_SYNC_OFFSET + H_SYNC_LEN);
    vsync_raw = (32'(v_q) >= 32'(vact_q) + V_SYNC_OFFSET) &&
                (32'(v_q) <  32'(vact_q) + V_SYNC_OFFSET + V_SYNC_LEN);
    sync_in   = {x_valid_q & y_valid_q, hsync_raw, vsync_raw};
    rgb_d     = sync_out[2] ? Data_VGA : '0;
    hsync_d   = sync_out[1] ? SYNC_POL : ~SYNC_POL;
    vsync_d   = sync_out[0] ? SYNC_POL : ~SYNC_POL;
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY),
    .WIDTH (3)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sync_in),
    .dout  (sync_out)
  );

  // State registers; reset restores the reset geometry, not the last accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      htot_q        <= BACKPORCH_WIDTH'(H_TOTAL_RST);
      hact_q        <= FRONTPORCH_WIDTH'(H_ACTIVE_RST);
      vtot_q        <= BACKPORCH_WIDTH'(V_TOTAL_RST);
      vact_q        <= FRONTPORCH_WIDTH'(V_ACTIVE_RST);
      x_valid_q     <= 1'b1;
      y_valid_q     <= 1'b1;
      frame_start_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      rgb_q         <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      htot_q        <= htot_d;
      hact_q        <= hact_d;
      vtot_q        <= vtot_d;
      vact_q        <= vact_d;
      x_valid_q     <= x_valid_d;
      y_valid_q     <= y_valid_d;
      frame_start_q <= frame_start_d;
      cfg_err_q     <= cfg_err_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign Counter_X       = h_q;
  assign Counter_Y       = v_q;
  assign Counter_X_Valid = x_valid_q;
  assign Counter_Y_Valid = y_valid_q;
  assign HSYNC           = hsync_q;
  assign VSYNC           = vsync_q;
  assign RGB             = rgb_q;
  assign Frame_Start     = frame_start_q;
  assign Cfg_Error       = cfg_err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a scaled-down geometry so frames stay short.
module tb_vga_timing_gen;

  localparam int HT = 40, HA = 24, VT = 12, VA = 8;
  localparam int HSO = 4, HSL = 6, VSO = 1, VSL = 2;
  localparam int FRAME_A = HT * VT * 2;
  localparam int FRAME_B = HT * VT;
  localparam logic [11:0] DATA_A = 12'hABC;
  localparam logic [11:0] DATA_B = 12'h5A3;

  int tests = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic [10:0] a_hbp = 11'(HT), a_hfp = 11'(HA), a_vbp = 11'(VT), a_vfp = 11'(VA);
  logic [10:0] b_hbp = 11'(HT), b_hfp = 11'(HA), b_vbp = 11'(VT), b_vfp = 11'(VA);
  logic [11:0] data_a = DATA_A, data_b = DATA_B;

  logic [10:0] a_x, a_y, b_x, b_y;
  logic        a_xv, a_yv, a_hs, a_vs, a_fs, a_err;
  logic        b_xv, b_yv, b_hs, b_vs, b_fs, b_err;
  logic [11:0] a_rgb, b_rgb;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .PIX_DIV (2), .PIPE_DELAY (1),
    .H_SYNC_OFFSET (HSO), .H_SYNC_LEN (HSL), .V_SYNC_OFFSET (VSO), .V_SYNC_LEN (VSL),
    .H_TOTAL_RST (HT), .H_ACTIVE_RST (HA), .V_TOTAL_RST (VT), .V_ACTIVE_RST (VA)
  ) dut_a (
    .clk (clk), .rst_n (rst_a),
    .H_BackPorch (a_hbp), .H_FrontPorch (a_hfp), .V_BackPorch (a_vbp), .V_FrontPorch (a_vfp),
    .Data_VGA (data_a),
    .Counter_X (a_x), .Counter_X_Valid (a_xv), .Counter_Y (a_y), .Counter_Y_Valid (a_yv),
    .HSYNC (a_hs), .VSYNC (a_vs), .RGB (a_rgb), .Frame_Start (a_fs), .Cfg_Error (a_err)
  );

  vga_timing_gen #(
    .PIX_DIV (1), .PIPE_DELAY (3),
    .H_SYNC_OFFSET (HSO), .H_SYNC_LEN (HSL), .V_SYNC_OFFSET (VSO), .V_SYNC_LEN (VSL),
    .H_TOTAL_RST (HT), .H_ACTIVE_RST (HA), .V_TOTAL_RST (VT), .V_ACTIVE_RST (VA)
  ) dut_b (
    .clk (clk), .rst_n (rst_b),
    .H_BackPorch (b_hbp), .H_FrontPorch (b_hfp), .V_BackPorch (b_vbp), .V_FrontPorch (b_vfp),
    .Data_VGA (data_b),
    .Counter_X (b_x), .Counter_X_Valid (b_xv), .Counter_Y (b_y), .Counter_Y_Valid (b_yv),
    .HSYNC (b_hs), .VSYNC (b_vs), .RGB (b_rgb), .Frame_Start (b_fs), .Cfg_Error (b_err)
  );

  function automatic bit in_win(int x, int start, int len);
    return (x >= start) && (x < start + len);
  endfunction

  // Pulse reset on DUT A, releasing it on a falling edge.
  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic test_reset();
    logic [40:0] exp_v;
    exp_v = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 1'b0, 1'b0};
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({a_x, a_y, a_xv, a_yv, a_hs, a_vs, a_rgb, a_fs, a_err} !== exp_v) begin
      failures++;
      $display("FAIL reset_a got=%h exp=%h", {a_x, a_y, a_xv, a_yv, a_hs, a_vs, a_rgb, a_fs, a_err}, exp_v);
    end
    tests++;
    if ({b_x, b_y, b_xv, b_yv, b_hs, b_vs, b_rgb, b_fs, b_err} !== exp_v) begin
      failures++;
      $display("FAIL reset_b got=%h exp=%h", {b_x, b_y, b_xv, b_yv, b_hs, b_vs, b_rgb, b_fs, b_err}, exp_v);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
  endtask

  task automatic test_counting();
    int p, h, v;
    reset_a();
    for (int n = 1; n <= 2 * FRAME_A + 10; n++) begin
      @(negedge clk);
      p = n / 2; h = p % HT; v = (p / HT) % VT;
      tests++;
      if (a_x !== 11'(h)) begin failures++; $display("FAIL cnt_x n=%0d got=%0d exp=%0d", n, a_x, h); end
      tests++;
      if (a_y !== 11'(v)) begin failures++; $display("FAIL cnt_y n=%0d got=%0d exp=%0d", n, a_y, v); end
      tests++;
      if ({a_xv, a_yv} !== {h < HA, v < VA}) begin
        failures++; $display("FAIL cnt_valid n=%0d got=%b%b exp=%b%b", n, a_xv, a_yv, h < HA, v < VA);
      end
      tests++;
      if (a_fs !== (n % FRAME_A == 0)) begin
        failures++; $display("FAIL frame_start n=%0d got=%b exp=%b", n, a_fs, n % FRAME_A == 0);
      end
    end
  endtask

  task automatic test_sync();
    int m, p, h, v;
    logic ehs, evs;
    reset_a();
    for (int n = 1; n <= FRAME_A + 4; n++) begin
      @(negedge clk);
      m = n - 2; p = m / 2; h = p % HT; v = (p / HT) % VT;
      ehs = !(m >= 0 && in_win(h, HA + HSO, HSL));
      evs = !(m >= 0 && in_win(v, VA + VSO, VSL));
      tests++;
      if (a_hs !== ehs) begin failures++; $display("FAIL hsync n=%0d got=%b exp=%b", n, a_hs, ehs); end
      tests++;
      if (a_vs !== evs) begin failures++; $display("FAIL vsync n=%0d got=%b exp=%b", n, a_vs, evs); end
    end
  endtask

  task automatic test_blanking();
    int m, p, h, v;
    logic [11:0] erg;
    reset_a();
    for (int n = 1; n <= FRAME_A + 4; n++) begin
      @(negedge clk);
      m = n - 2; p = m / 2; h = p % HT; v = (p / HT) % VT;
      erg = (m >= 0 && h < HA && v < VA) ? DATA_A : 12'h000;
      tests++;
      if (a_rgb !== erg) begin failures++; $display("FAIL rgb n=%0d got=%h exp=%h", n, a_rgb, erg); end
    end
  endtask

  task automatic test_reconfig();
    int p, q, h, v, ha;
    reset_a();
    for (int n = 1; n <= FRAME_A + 2 * 60 * 3; n++) begin
      @(negedge clk);
      if (n < FRAME_A) begin
        p = n / 2; h = p % HT; v = p / HT; ha = HA;
      end else begin
        q = (n - FRAME_A) / 2; h = q % 60; v = q / 60; ha = 36;
      end
      tests++;
      if ({a_x, a_y} !== {11'(h), 11'(v)}) begin
        failures++; $display("FAIL reconf_xy n=%0d got=%0d,%0d exp=%0d,%0d", n, a_x, a_y, h, v);
      end
      tests++;
      if (a_xv !== (h < ha)) begin failures++; $display("FAIL reconf_xv n=%0d got=%b exp=%b", n, a_xv, h < ha); end
      tests++;
      if (a_err !== 1'b0) begin failures++; $display("FAIL reconf_err n=%0d got=%b exp=0", n, a_err); end
      if (n == 2 * HT * 4) begin
        a_hbp = 11'd60; a_hfp = 11'd36; a_vbp = 11'd16; a_vfp = 11'd10;
      end
    end
    a_hbp = 11'(HT); a_hfp = 11'(HA); a_vbp = 11'(VT); a_vfp = 11'(VA);
  endtask

  task automatic test_invalid_cfg();
    int p, h, v;
    logic eerr;
    reset_a();
    a_hfp = 11'd50;
    for (int n = 1; n <= 3 * FRAME_A + 2 * HT * 2; n++) begin
      @(negedge clk);
      p = n / 2; h = p % HT; v = (p / HT) % VT;
      eerr = (n >= FRAME_A) && (n < 3 * FRAME_A);
      tests++;
      if ({a_x, a_y} !== {11'(h), 11'(v)}) begin
        failures++; $display("FAIL badcfg_xy n=%0d got=%0d,%0d exp=%0d,%0d", n, a_x, a_y, h, v);
      end
      tests++;
      if (a_xv !== (h < HA)) begin failures++; $display("FAIL badcfg_xv n=%0d got=%b exp=%b", n, a_xv, h < HA); end
      tests++;
      if (a_err !== eerr) begin failures++; $display("FAIL cfg_error n=%0d got=%b exp=%b", n, a_err, eerr); end
      if (n == FRAME_A + 40) a_hfp = 11'd32;
      if (n == 3 * FRAME_A - 1) a_hfp = 11'(HA);
    end
  endtask

  task automatic test_async_reset();
    int p, h, v;
    logic [40:0] exp_v;
    exp_v = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 1'b0, 1'b0};
    reset_a();
    a_hbp = 11'd60; a_hfp = 11'd36; a_vbp = 11'd16; a_vfp = 11'd10;
    repeat (FRAME_A + 660) @(negedge clk);
    tests++;
    if ({a_x, a_y, a_rgb} !== {11'd30, 11'd5, DATA_A}) begin
      failures++; $display("FAIL pre_reset got=%0d,%0d,%h exp=30,5,%h", a_x, a_y, a_rgb, DATA_A);
    end
    #2 rst_a = 1'b0;
    #1;
    tests++;
    if ({a_x, a_y, a_xv, a_yv, a_hs, a_vs, a_rgb, a_fs, a_err} !== exp_v) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", {a_x, a_y, a_xv, a_yv, a_hs, a_vs, a_rgb, a_fs, a_err}, exp_v);
    end
    @(negedge clk);
    rst_a = 1'b1;
    for (int n = 1; n <= 2 * HT * 2 + 4; n++) begin
      @(negedge clk);
      p = n / 2; h = p % HT; v = p / HT;
      tests++;
      if ({a_x, a_y, a_xv} !== {11'(h), 11'(v), h < HA}) begin
        failures++; $display("FAIL post_reset n=%0d got=%0d,%0d,%b exp=%0d,%0d,%b", n, a_x, a_y, a_xv, h, v, h < HA);
      end
    end
    a_hbp = 11'(HT); a_hfp = 11'(HA); a_vbp = 11'(VT); a_vfp = 11'(VA);
  endtask

  task automatic test_fast_pipe();
    int m, h, v, mh, mv;
    logic [11:0] erg;
    logic ehs, evs;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    for (int n = 1; n <= 2 * FRAME_B + 5; n++) begin
      @(negedge clk);
      h = n % HT; v = (n / HT) % VT;
      m = n - 4; mh = m % HT; mv = (m / HT) % VT;
      erg = (m >= 0 && mh < HA && mv < VA) ? DATA_B : 12'h000;
      ehs = !(m >= 0 && in_win(mh, HA + HSO, HSL));
      evs = !(m >= 0 && in_win(mv, VA + VSO, VSL));
      tests++;
      if ({b_x, b_y} !== {11'(h), 11'(v)}) begin
        failures++; $display("FAIL fast_xy n=%0d got=%0d,%0d exp=%0d,%0d", n, b_x, b_y, h, v);
      end
      tests++;
      if (b_rgb !== erg) begin failures++; $display("FAIL fast_rgb n=%0d got=%h exp=%h", n, b_rgb, erg); end
      tests++;
      if ({b_hs, b_vs} !== {ehs, evs}) begin
        failures++; $display("FAIL fast_sync n=%0d got=%b%b exp=%b%b", n, b_hs, b_vs, ehs, evs);
      end
      tests++;
      if (b_fs !== (n % FRAME_B == 0)) begin
        failures++; $display("FAIL fast_fs n=%0d got=%b exp=%b", n, b_fs, n % FRAME_B == 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_counting();
    test_sync();
    test_blanking();
    test_reconfig();
    test_invalid_cfg();
    test_async_reset();
    test_fast_pipe();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
